// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan controller.
package display_pkg;
    localparam int DIGIT_W    = 4;
    localparam int MAX_DIGITS = 32;

    typedef enum logic [1:0] {OFF, SHOW, BLANK} scan_state_t;

    function automatic logic [MAX_DIGITS-1:0] onehot(input int unsigned idx);
        return MAX_DIGITS'(1) << idx;
    endfunction
endpackage

// File: rtl/display_scan_timer.sv
// Loadable down-counter shared by the SHOW and BLANK phases; parks at zero.
module display_scan_timer
    import display_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic [CNT_W-1:0] o_count,
    output logic             o_last
);
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear)
            r_count <= '0;
        else if (i_load)
            r_count <= i_load_val;
        else if (r_count != '0)
            r_count <= r_count - 1'b1;
    end

    assign o_count = r_count;
    assign o_last  = (r_count == CNT_W'(1));
endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit 7-segment display.
// Optional leading-zero blanking is enabled by defining DISPLAY_SCAN_LZB_EN.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] load_digits,
    input  logic [NUM_DIGITS-1:0]         load_dp,
    output logic [DIGIT_W-1:0]            data,
    output logic                          dp,
    output logic [NUM_DIGITS-1:0]         an,
    output logic                          frame_tick
);
    localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    scan_state_t                           r_state;
    logic [IDX_W-1:0]                      r_idx;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]    r_disp, r_pend;
    logic [NUM_DIGITS-1:0]                 r_disp_dp, r_pend_dp;
    logic                                  r_pend_full, r_ready, r_dp, r_tick;
    logic [DIGIT_W-1:0]                    r_data;
    logic [NUM_DIGITS-1:0]                 r_an;

    logic [CNT_W-1:0]                      w_count;
    logic                                  w_last, w_zero, w_wrap, w_commit, w_accept;
    logic                                  w_start_show, w_end_show, w_pend_full_nxt;
    logic [IDX_W-1:0]                      w_show_idx;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]    w_src_digits;
    logic [NUM_DIGITS-1:0]                 w_src_dp, w_lit_mask, w_an_next;

    display_scan_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (!enable),
        .i_load     (w_start_show || w_end_show),
        .i_load_val (w_start_show ? CNT_W'(SCAN_DIV) : CNT_W'(BLANK_CYCLES)),
        .o_count    (w_count),
        .o_last     (w_last)
    );

    // Counter at zero while in SHOW only happens right after reset: treat it as a scan start.
    assign w_zero       = (w_count == '0);
    assign w_wrap       = (r_state == BLANK) && w_last && (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_commit     = r_pend_full && (!enable || w_wrap);
    assign w_accept     = load_valid && !r_pend_full;
    assign w_start_show = enable && ((r_state == OFF) || ((r_state == SHOW) && w_zero) ||
                                     ((r_state == BLANK) && w_last));
    assign w_end_show   = enable && (r_state == SHOW) && w_last;
    assign w_pend_full_nxt = w_commit ? 1'b0 : (w_accept ? 1'b1 : r_pend_full);

    assign w_src_digits = w_commit ? r_pend    : r_disp;
    assign w_src_dp     = w_commit ? r_pend_dp : r_disp_dp;

    always_comb begin
        w_show_idx = '0;
        if ((r_state == BLANK) && !w_wrap)
            w_show_idx = r_idx + IDX_W'(1);
    end

`ifdef DISPLAY_SCAN_LZB_EN
    logic [NUM_DIGITS-1:0] w_hi_zero;
    always_comb begin
        w_hi_zero = '0;
        w_hi_zero[NUM_DIGITS-1] = (w_src_digits[NUM_DIGITS-1] == '0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--)
            w_hi_zero[i] = (w_src_digits[i] == '0) && w_hi_zero[i+1];
    end
    // Digit 0 always lights so a zero value still shows "0".
    assign w_lit_mask = ~w_hi_zero | NUM_DIGITS'(1);
`else
    assign w_lit_mask = '1;
`endif

    assign w_an_next = NUM_DIGITS'(onehot(int'(w_show_idx))) & w_lit_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= SHOW;
            r_idx       <= '0;
            r_disp      <= '0;
            r_disp_dp   <= '0;
            r_pend      <= '0;
            r_pend_dp   <= '0;
            r_pend_full <= 1'b0;
            r_ready     <= 1'b1;
            r_an        <= '0;
            r_data      <= '0;
            r_dp        <= 1'b0;
            r_tick      <= 1'b0;
        end else begin
            r_tick      <= 1'b0;
            r_pend_full <= w_pend_full_nxt;
            r_ready     <= !w_pend_full_nxt;
            if (w_accept) begin
                r_pend    <= load_digits;
                r_pend_dp <= load_dp;
            end
            if (w_commit) begin
                r_disp    <= r_pend;
                r_disp_dp <= r_pend_dp;
            end
            if (!enable) begin
                r_state <= OFF;
                r_idx   <= '0;
                r_an    <= '0;
            end else if (w_start_show) begin
                r_state <= SHOW;
                r_idx   <= w_show_idx;
                r_an    <= w_an_next;
                r_data  <= w_src_digits[w_show_idx];
                r_dp    <= w_src_dp[w_show_idx];
                r_tick  <= w_wrap;
            end else if (w_end_show) begin
                r_state <= BLANK;
                r_an    <= '0;
            end
        end
    end

    assign load_ready = r_ready;
    assign an         = r_an;
    assign data       = r_data;
    assign dp         = r_dp;
    assign frame_tick = r_tick;
endmodule
